// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: runs mult/div as fixed-latency operations,
// owns HI/LO, serves mfhi/mflo and raises the D-stage MD hazard stall.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;

  logic              accept, issue, is_mul_div;
  logic [63:0]       prod_s, prod_u;
  logic              div_signed, a_neg, b_neg;
  logic [31:0]       a_mag, b_mag, b_safe, uq, ur, quo, rem;

  assign is_mul_div = (md_op >= OpMult) && (md_op <= OpDivu);
  assign accept     = start & ~cancel & (state_q == StIdle);
  assign issue      = accept & is_mul_div;

  // Sign-extended 64-bit operands make the low 64 bits of the product the signed result.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // One unsigned divider on magnitudes; signs reapplied afterwards. Also covers
  // 0x80000000 / -1, whose magnitude quotient 2^31 reads back as 0x80000000.
  assign div_signed = (op_q == OpDiv);
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign a_mag      = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag      = b_neg ? (32'd0 - b_q) : b_q;
  assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq         = a_mag / b_safe;
  assign ur         = a_mag % b_safe;
  assign quo        = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem        = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          a_d     = d1;
          b_d     = d2;
          op_d    = md_op;
          cnt_d   = (md_op <= OpMultu) ? CntW'(MULT_CYCLES - 1) : CntW'(DIV_CYCLES - 1);
          state_d = StRun;
        end else if (accept) begin
          if (md_op == OpMthi) hi_d = d1;
          if (md_op == OpMtlo) lo_d = d1;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (op_q == OpMult) begin
            hi_d = prod_s[63:32];
            lo_d = prod_s[31:0];
          end else if (op_q == OpMultu) begin
            hi_d = prod_u[63:32];
            lo_d = prod_u[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign stall_md = d_is_md & (busy | issue);
  assign result   = (md_op == OpMfhi) ? hi_q : (md_op == OpMflo) ? lo_q : 32'd0;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
